// File: rtl/mapper_pkg.sv
// Shared types for the translation-table fill engine: fill modes, FSM states, default widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mapper_pkg;

  localparam int IDX_W_DEF  = 7;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    FILL_IDENTITY = 2'd0,
    FILL_CONST    = 2'd1,
    FILL_INCR     = 2'd2,
    FILL_RSVD     = 2'd3
  } fill_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_VERIFY = 2'd2,
    ST_DONE   = 2'd3
  } fill_state_e;

endpackage

// File: rtl/trans_table_filler_if.sv
// Translation-table SRAM pin bundle (address, data, strobes).
// Latency: none, plain wires.
// Backpressure: none; the asynchronous SRAM answers in the same cycle.
interface trans_table_filler_if
  import mapper_pkg::*;
#(
  parameter int IDX_W  = IDX_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic [IDX_W-1:0]  tbl_addr;
  logic [DATA_W-1:0] tbl_wdata;
  logic [DATA_W-1:0] tbl_rdata;
  logic              tbl_we_n;
  logic              tbl_oe_n;

  modport master (output tbl_addr, output tbl_wdata, output tbl_we_n, output tbl_oe_n,
                  input tbl_rdata);
  modport slave  (input tbl_addr, input tbl_wdata, input tbl_we_n, input tbl_oe_n,
                  output tbl_rdata);
endinterface

// File: rtl/fill_pattern_gen.sv
// Combinational table-entry pattern for a given index, mode and seed value.
// Latency: zero cycles (pure combinational).
// Backpressure: none.
module fill_pattern_gen
  import mapper_pkg::*;
#(
  parameter int IDX_W  = IDX_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [IDX_W-1:0]  idx,
  input  fill_mode_e        mode,
  input  logic [DATA_W-1:0] value,
  output logic [DATA_W-1:0] pattern
);

  logic [DATA_W-1:0] idx_ext;
  assign idx_ext = DATA_W'(idx);

  // Select the pattern; arithmetic wraps at DATA_W bits.
  always_comb begin
    pattern = '0;
    case (mode)
      FILL_IDENTITY: pattern = idx_ext;
      FILL_CONST:    pattern = value;
      FILL_INCR:     pattern = value + idx_ext;
      default:       pattern = '0;
    endcase
  end

endmodule

// File: rtl/trans_table_filler.sv
// Arbitrates the translation-table SRAM between the mapper (always wins) and a fill/verify engine.
// Latency: CPU path is combinational; a fill takes 2^IDX_W engine-granted cycles (twice that with verify).
// Backpressure: any cpu_req cycle stalls the engine index; no timeout. Optional verify pass: FILL_VERIFY_EN.
module trans_table_filler
  import mapper_pkg::*;
#(
  parameter int IDX_W  = IDX_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [IDX_W-1:0]  cpu_index,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              cmd_start,
  input  logic              cmd_abort,
  input  logic [1:0]        cmd_mode,
  input  logic [DATA_W-1:0] cmd_value,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              verify_err,
  output logic [IDX_W-1:0]  err_index,
  trans_table_filler_if.master tbl
);

  localparam logic [IDX_W-1:0] IDX_LAST = '1;

  fill_state_e       state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  fill_mode_e        mode_q, mode_d;
  logic [DATA_W-1:0] value_q, value_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              aborted_q, aborted_d;
  logic [DATA_W-1:0] pat;
  logic              eng_gnt;
  logic              start_ok;

  assign eng_gnt  = !cpu_req;
  assign start_ok = cmd_start && !cmd_abort && (cmd_mode != 2'd3) &&
                    ((state_q == ST_IDLE) || (state_q == ST_DONE));

  // One generator serves both the fill write data and the verify compare.
  fill_pattern_gen #(.IDX_W(IDX_W), .DATA_W(DATA_W)) u_pat (
    .idx     (idx_q),
    .mode    (mode_q),
    .value   (value_q),
    .pattern (pat)
  );

`ifdef FILL_VERIFY_EN
  logic             verr_q, verr_d;
  logic [IDX_W-1:0] err_idx_q, err_idx_d;
`endif

  // Next-state logic: command acceptance, index stepping, completion and abort.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    mode_d    = mode_q;
    value_d   = value_q;
    aborted_d = aborted_q;
`ifdef FILL_VERIFY_EN
    verr_d    = verr_q;
    err_idx_d = err_idx_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start_ok) begin
          state_d   = ST_FILL;
          idx_d     = '0;
          mode_d    = fill_mode_e'(cmd_mode);
          value_d   = cmd_value;
          aborted_d = 1'b0;
`ifdef FILL_VERIFY_EN
          verr_d    = 1'b0;
          err_idx_d = '0;
`endif
        end
      end
      ST_FILL: begin
        if (eng_gnt) begin
          idx_d = idx_q + 1'b1;
          if (idx_q == IDX_LAST) begin
`ifdef FILL_VERIFY_EN
            state_d = ST_VERIFY;
`else
            state_d = ST_DONE;
`endif
          end
        end
      end
`ifdef FILL_VERIFY_EN
      ST_VERIFY: begin
        if (eng_gnt) begin
          // Only the first mismatch is recorded; the pass still runs to the end.
          if ((tbl.tbl_rdata != pat) && !verr_q) begin
            verr_d    = 1'b1;
            err_idx_d = idx_q;
          end
          idx_d = idx_q + 1'b1;
          if (idx_q == IDX_LAST) state_d = ST_DONE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
    // Abort beats completion; the in-flight write of this cycle still lands.
    if (cmd_abort && ((state_q == ST_FILL) || (state_q == ST_VERIFY))) begin
      state_d   = ST_IDLE;
      idx_d     = '0;
      aborted_d = 1'b1;
    end
    busy_d = (state_d == ST_FILL) || (state_d == ST_VERIFY);
    done_d = (state_d == ST_DONE);
  end

  // State and registered status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      mode_q    <= FILL_IDENTITY;
      value_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      mode_q    <= mode_d;
      value_q   <= value_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

`ifdef FILL_VERIFY_EN
  // Sticky first-mismatch record.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      verr_q    <= 1'b0;
      err_idx_q <= '0;
    end else begin
      verr_q    <= verr_d;
      err_idx_q <= err_idx_d;
    end
  end
  assign verify_err = verr_q;
  assign err_index  = err_idx_q;
`else
  assign verify_err = 1'b0;
  assign err_index  = '0;
`endif

  // Port grant: the mapper takes the SRAM whenever it asks, otherwise the engine drives it.
  always_comb begin
    tbl.tbl_addr  = '0;
    tbl.tbl_wdata = '0;
    tbl.tbl_we_n  = 1'b1;
    tbl.tbl_oe_n  = 1'b0;
    if (cpu_req) begin
      tbl.tbl_addr  = cpu_index;
      tbl.tbl_wdata = cpu_wdata;
      tbl.tbl_we_n  = !cpu_wr;
      tbl.tbl_oe_n  = cpu_wr;
    end else if (state_q == ST_FILL) begin
      tbl.tbl_addr  = idx_q;
      tbl.tbl_wdata = pat;
      tbl.tbl_we_n  = 1'b0;
      tbl.tbl_oe_n  = 1'b1;
    end else if (state_q == ST_VERIFY) begin
      tbl.tbl_addr  = idx_q;
    end
  end

  assign cpu_rdata = tbl.tbl_rdata;
  assign busy      = busy_q;
  assign done      = done_q;
  assign aborted   = aborted_q;

endmodule

// File: tb/tb_trans_table_filler.sv
// Directed bench for trans_table_filler with a behavioural asynchronous SRAM model.
// Latency: n/a.
// Backpressure: cpu_req is driven by the bench to stall the engine.
module tb_trans_table_filler;

`ifdef FILL_VERIFY_EN
  localparam int VX = 2;
`else
  localparam int VX = 1;
`endif

  logic       clk;
  logic       reset_n;
  logic       cpu_req, cpu_wr;
  logic [6:0] cpu_index;
  logic [7:0] cpu_wdata, cpu_rdata;
  logic       cmd_start, cmd_abort;
  logic [1:0] cmd_mode;
  logic [7:0] cmd_value;
  logic       busy, done, aborted, verify_err;
  logic [6:0] err_index;
  logic [7:0] mem [128];
  logic       corrupt;
  int         n_chk;
  int         n_pass;

  trans_table_filler_if tif ();

  trans_table_filler dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cpu_req    (cpu_req),
    .cpu_wr     (cpu_wr),
    .cpu_index  (cpu_index),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cmd_start  (cmd_start),
    .cmd_abort  (cmd_abort),
    .cmd_mode   (cmd_mode),
    .cmd_value  (cmd_value),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
    .verify_err (verify_err),
    .err_index  (err_index),
    .tbl        (tif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model; optionally corrupts writes to entry 0x33.
  always @(posedge clk) begin
    if (tif.tbl_we_n === 1'b0)
      mem[tif.tbl_addr] <= (corrupt && tif.tbl_addr == 7'h33) ? ~tif.tbl_wdata : tif.tbl_wdata;
  end
  assign tif.tbl_rdata = mem[tif.tbl_addr];

  initial begin
    #3000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic do_start(input logic [1:0] mode, input logic [7:0] value);
    cmd_start = 1'b1; cmd_mode = mode; cmd_value = value;
    @(posedge clk); #1;
    cmd_start = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; cpu_req = 0; cpu_wr = 0; cpu_index = '0; cpu_wdata = '0;
    cmd_start = 0; cmd_abort = 0; cmd_mode = 0; cmd_value = 0; corrupt = 0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy got=%0h exp=0", busy); else n_pass++;
    n_chk++; if (done !== 1'b0) $display("FAIL reset_done got=%0h exp=0", done); else n_pass++;
    n_chk++; if (aborted !== 1'b0) $display("FAIL reset_aborted got=%0h exp=0", aborted); else n_pass++;
    n_chk++; if (verify_err !== 1'b0) $display("FAIL reset_verr got=%0h exp=0", verify_err); else n_pass++;
    n_chk++; if (err_index !== 7'h00) $display("FAIL reset_erridx got=%0h exp=0", err_index); else n_pass++;
    n_chk++; if (tif.tbl_we_n !== 1'b1) $display("FAIL reset_we_n got=%0h exp=1", tif.tbl_we_n); else n_pass++;
    n_chk++; if (tif.tbl_oe_n !== 1'b0) $display("FAIL reset_oe_n got=%0h exp=0", tif.tbl_oe_n); else n_pass++;
    n_chk++; if (tif.tbl_addr !== 7'h00) $display("FAIL reset_addr got=%0h exp=0", tif.tbl_addr); else n_pass++;
    n_chk++; if (tif.tbl_wdata !== 8'h00) $display("FAIL reset_wdata got=%0h exp=0", tif.tbl_wdata); else n_pass++;
    reset_n = 1'b1;
    @(posedge clk); #1;
    n_chk++; if (busy !== 1'b0) $display("FAIL post_reset_busy got=%0h exp=0", busy); else n_pass++;
  endtask

  task automatic test_identity;
    int done_cyc;
    done_cyc = 0;
    do_start(2'd0, 8'h00);
    n_chk++; if (busy !== 1'b1) $display("FAIL id_busy_c1 got=%0h exp=1", busy); else n_pass++;
    n_chk++; if (tif.tbl_we_n !== 1'b0) $display("FAIL id_we_c1 got=%0h exp=0", tif.tbl_we_n); else n_pass++;
    for (int n = 1; n <= 400; n++) begin
      if (done === 1'b1) begin done_cyc = n; break; end
      @(posedge clk); #1;
    end
    n_chk++; if (done_cyc != 128 * VX + 1) $display("FAIL id_done_cycle got=%0d exp=%0d", done_cyc, 128 * VX + 1); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL id_busy_at_done got=%0h exp=0", busy); else n_pass++;
    n_chk++; if (mem[7'h45] !== 8'h45) $display("FAIL id_mem45 got=%0h exp=45", mem[7'h45]); else n_pass++;
    n_chk++; if (mem[7'h7F] !== 8'h7F) $display("FAIL id_mem7f got=%0h exp=7f", mem[7'h7F]); else n_pass++;
    n_chk++; if (verify_err !== 1'b0) $display("FAIL id_verr got=%0h exp=0", verify_err); else n_pass++;
    @(posedge clk); #1;
    n_chk++; if (done !== 1'b0) $display("FAIL id_done_one_cycle got=%0h exp=0", done); else n_pass++;
  endtask

  task automatic test_incr_cpu;
    int done_cyc;
    logic [7:0] exp_rd;
    done_cyc = 0;
    do_start(2'd2, 8'hFE);
    cmd_value = 8'h00;   // must not affect the captured seed
    cmd_mode  = 2'd1;
    for (int n = 1; n <= 1200; n++) begin
      if (done === 1'b1) begin done_cyc = n; break; end
      cpu_req   = (n % 2 == 0);
      cpu_wr    = 1'b0;
      cpu_index = 7'h70 + 7'((n / 2) & 15);
      #1;
      if (cpu_req && n <= 12) begin
        exp_rd = 8'h70 + 8'(n / 2);
        n_chk++; if (cpu_rdata !== exp_rd) $display("FAIL incr_cpu_rd n=%0d got=%0h exp=%0h", n, cpu_rdata, exp_rd); else n_pass++;
        n_chk++; if (tif.tbl_we_n !== 1'b1) $display("FAIL incr_cpu_we n=%0d got=%0h exp=1", n, tif.tbl_we_n); else n_pass++;
      end
      @(posedge clk); #1;
    end
    cpu_req = 1'b0;
    n_chk++; if (done_cyc != 256 * VX) $display("FAIL incr_done_cycle got=%0d exp=%0d", done_cyc, 256 * VX); else n_pass++;
    n_chk++; if (mem[0] !== 8'hFE) $display("FAIL incr_mem0 got=%0h exp=fe", mem[0]); else n_pass++;
    n_chk++; if (mem[1] !== 8'hFF) $display("FAIL incr_mem1 got=%0h exp=ff", mem[1]); else n_pass++;
    n_chk++; if (mem[2] !== 8'h00) $display("FAIL incr_mem2 got=%0h exp=00", mem[2]); else n_pass++;
    n_chk++; if (mem[7'h7F] !== 8'h7D) $display("FAIL incr_mem7f got=%0h exp=7d", mem[7'h7F]); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_abort;
    int saw_done;
    saw_done = 0;
    do_start(2'd1, 8'hA5);
    for (int n = 1; n < 33; n++) begin
      if (done === 1'b1) saw_done++;
      @(posedge clk); #1;
    end
    cmd_abort = 1'b1;
    #1;
    n_chk++; if (tif.tbl_addr !== 7'h20) $display("FAIL abort_addr got=%0h exp=20", tif.tbl_addr); else n_pass++;
    n_chk++; if (tif.tbl_wdata !== 8'hA5) $display("FAIL abort_wdata got=%0h exp=a5", tif.tbl_wdata); else n_pass++;
    @(posedge clk); #1;
    cmd_abort = 1'b0;
    n_chk++; if (busy !== 1'b0) $display("FAIL abort_busy got=%0h exp=0", busy); else n_pass++;
    n_chk++; if (aborted !== 1'b1) $display("FAIL abort_flag got=%0h exp=1", aborted); else n_pass++;
    for (int n = 0; n < 6; n++) begin
      if (done === 1'b1) saw_done++;
      @(posedge clk); #1;
    end
    n_chk++; if (saw_done != 0) $display("FAIL abort_no_done got=%0d exp=0", saw_done); else n_pass++;
    n_chk++; if (mem[0] !== 8'hA5) $display("FAIL abort_mem00 got=%0h exp=a5", mem[0]); else n_pass++;
    n_chk++; if (mem[7'h20] !== 8'hA5) $display("FAIL abort_mem20 got=%0h exp=a5", mem[7'h20]); else n_pass++;
    n_chk++; if (mem[7'h21] !== 8'h1F) $display("FAIL abort_mem21 got=%0h exp=1f", mem[7'h21]); else n_pass++;
  endtask

  task automatic test_start_abort_same;
    cmd_start = 1'b1; cmd_abort = 1'b1; cmd_mode = 2'd0;
    @(posedge clk); #1;
    cmd_start = 1'b0; cmd_abort = 1'b0;
    n_chk++; if (busy !== 1'b0) $display("FAIL sa_busy got=%0h exp=0", busy); else n_pass++;
    n_chk++; if (aborted !== 1'b1) $display("FAIL sa_aborted got=%0h exp=1", aborted); else n_pass++;
    n_chk++; if (tif.tbl_we_n !== 1'b1) $display("FAIL sa_we_n got=%0h exp=1", tif.tbl_we_n); else n_pass++;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (mem[7'h21] !== 8'h1F) $display("FAIL sa_mem21 got=%0h exp=1f", mem[7'h21]); else n_pass++;
  endtask

  task automatic test_mode3_and_busy_start;
    int done_cyc;
    done_cyc = 0;
    do_start(2'd3, 8'h55);
    n_chk++; if (busy !== 1'b0) $display("FAIL m3_busy got=%0h exp=0", busy); else n_pass++;
    n_chk++; if (aborted !== 1'b1) $display("FAIL m3_aborted got=%0h exp=1", aborted); else n_pass++;
    do_start(2'd1, 8'h3C);
    n_chk++; if (aborted !== 1'b0) $display("FAIL m1_aborted_clr got=%0h exp=0", aborted); else n_pass++;
    for (int n = 1; n <= 400; n++) begin
      if (done === 1'b1) begin done_cyc = n; break; end
      cmd_start = (n == 5);   // restart attempt while busy
      cmd_mode  = 2'd0;
      @(posedge clk); #1;
    end
    cmd_start = 1'b0;
    n_chk++; if (done_cyc != 128 * VX + 1) $display("FAIL busy_start_done got=%0d exp=%0d", done_cyc, 128 * VX + 1); else n_pass++;
    n_chk++; if (mem[7'h10] !== 8'h3C) $display("FAIL busy_start_mem10 got=%0h exp=3c", mem[7'h10]); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midfill;
    do_start(2'd0, 8'h00);
    repeat (9) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    n_chk++; if (busy !== 1'b0) $display("FAIL rst_mid_busy got=%0h exp=0", busy); else n_pass++;
    n_chk++; if (tif.tbl_we_n !== 1'b1) $display("FAIL rst_mid_we got=%0h exp=1", tif.tbl_we_n); else n_pass++;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    n_chk++; if (mem[7'h05] !== 8'h05) $display("FAIL rst_mid_mem05 got=%0h exp=05", mem[7'h05]); else n_pass++;
    n_chk++; if (mem[7'h20] !== 8'h3C) $display("FAIL rst_mid_mem20 got=%0h exp=3c", mem[7'h20]); else n_pass++;
  endtask

`ifdef FILL_VERIFY_EN
  task automatic test_verify;
    int done_cyc;
    done_cyc = 0;
    corrupt = 1'b1;
    do_start(2'd0, 8'h00);
    for (int n = 1; n <= 600; n++) begin
      if (done === 1'b1) begin done_cyc = n; break; end
      @(posedge clk); #1;
    end
    corrupt = 1'b0;
    n_chk++; if (done_cyc != 257) $display("FAIL verify_done got=%0d exp=257", done_cyc); else n_pass++;
    n_chk++; if (verify_err !== 1'b1) $display("FAIL verify_err got=%0h exp=1", verify_err); else n_pass++;
    n_chk++; if (err_index !== 7'h33) $display("FAIL verify_idx got=%0h exp=33", err_index); else n_pass++;
  endtask
`endif

  initial begin
    n_chk = 0;
    n_pass = 0;
    test_reset();
    test_identity();
    test_incr_cpu();
    test_abort();
    test_start_abort_same();
    test_mode3_and_busy_start();
    test_reset_midfill();
`ifdef FILL_VERIFY_EN
    test_verify();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
